// File: rtl/v2f_limb_alu_if.sv
// Request/response bundle for v2f_limb_alu: valid/ready request with opcode and operands,
// valid/ready response with result and flag.
interface v2f_limb_alu_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, flag
  );
endinterface

// File: rtl/v2f_limb_alu.sv
// Limb-serial wide ALU: one LIMB_WIDTH slice per clock, LSB first, carry/equality chained.
// Optional back-to-back retire+accept in DONE when V2F_LIMB_ALU_B2B_EN is defined.
module v2f_limb_alu #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LIMB_WIDTH = 32,
  parameter bit          A_SIGNED   = 1'b0,
  parameter bit          B_SIGNED   = 1'b0
) (
  input  logic          clk_i,
  input  logic          arst_i,
  v2f_limb_alu_if.slave bus_io
);

  localparam int unsigned NLIMBS  = (WIDTH + LIMB_WIDTH - 1) / LIMB_WIDTH;
  localparam int unsigned PadW    = NLIMBS * LIMB_WIDTH;
  localparam int unsigned TopBits = WIDTH - (NLIMBS - 1) * LIMB_WIDTH;
  localparam int unsigned IdxW    = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [LIMB_WIDTH-1:0] TopMask = {LIMB_WIDTH{1'b1}} >> (LIMB_WIDTH - TopBits);
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NLIMBS - 1);

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpEq, OpLt, OpRsvd
  } op_e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [PadW-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, eq_q, eq_d, flag_q, flag_d;

  logic                  last, sub_like, carry_out, diff_sign, ovf, lt, eq_final;
  logic                  in_ready, accept;
  logic [LIMB_WIDTH-1:0] mask, a_l, b_l, b_add, res_l;
  logic [LIMB_WIDTH:0]   sum;

  // Limb datapath; the top limb is masked so padding never reaches carry, eq or sign.
  always_comb begin
    last      = (idx_q == LastIdx);
    mask      = last ? TopMask : '1;
    a_l       = a_q[LIMB_WIDTH-1:0] & mask;
    b_l       = b_q[LIMB_WIDTH-1:0] & mask;
    sub_like  = (op_q == OpSub) || (op_q == OpLt);
    b_add     = (sub_like ? ~b_q[LIMB_WIDTH-1:0] : b_q[LIMB_WIDTH-1:0]) & mask;
    sum       = {1'b0, a_l} + {1'b0, b_add} + {{LIMB_WIDTH{1'b0}}, carry_q};
    carry_out = last ? sum[TopBits] : sum[LIMB_WIDTH];
    diff_sign = sum[TopBits-1];
    ovf       = (a_l[TopBits-1] ^ b_l[TopBits-1]) & (diff_sign ^ a_l[TopBits-1]);
    lt        = (A_SIGNED && B_SIGNED) ? (diff_sign ^ ovf) : ~carry_out;
    eq_final  = eq_q & (a_l == b_l);
    res_l     = '0;
    unique case (op_q)
      OpAdd, OpSub: res_l = sum[LIMB_WIDTH-1:0];
      OpAnd:        res_l = a_l & b_l;
      OpOr:         res_l = a_l | b_l;
      OpXor:        res_l = a_l ^ b_l;
      default:      res_l = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    flag_d   = flag_q;
    in_ready = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        a_d     = a_q >> LIMB_WIDTH;
        b_d     = b_q >> LIMB_WIDTH;
        y_d     = (y_q >> LIMB_WIDTH) | (PadW'(res_l) << (PadW - LIMB_WIDTH));
        carry_d = carry_out;
        eq_d    = eq_final;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          state_d = StDone;
          idx_d   = '0;
          unique case (op_q)
            OpAdd:   flag_d = carry_out;
            OpSub:   flag_d = ~carry_out;
            OpEq:    flag_d = eq_final;
            OpLt:    flag_d = lt;
            default: flag_d = 1'b0;
          endcase
          unique case (op_q)
            OpEq:    y_d = PadW'(eq_final);
            OpLt:    y_d = PadW'(lt);
            OpRsvd:  y_d = '0;
            default: ;
          endcase
        end
      end
      StDone: begin
`ifdef V2F_LIMB_ALU_B2B_EN
        in_ready = bus_io.out_ready;
`endif
        if (bus_io.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    accept = in_ready & bus_io.in_valid;
    if (accept) begin
      state_d = StRun;
      op_d    = op_e'(bus_io.op);
      a_d     = A_SIGNED ? PadW'($signed(bus_io.a)) : PadW'(bus_io.a);
      b_d     = B_SIGNED ? PadW'($signed(bus_io.b)) : PadW'(bus_io.b);
      y_d     = '0;
      idx_d   = '0;
      carry_d = (bus_io.op == OpSub) || (bus_io.op == OpLt);
      eq_d    = 1'b1;
      flag_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      flag_q  <= flag_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.y         = y_q[WIDTH-1:0];
  assign bus_io.flag      = flag_q;

endmodule

// File: tb/tb_v2f_limb_alu.sv
// Directed bench: four ALU configurations (64u, 64s, 40u, 128u) share one stimulus stream.
module tb_v2f_limb_alu;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd4, OP_EQ = 3'd5;
  localparam logic [2:0] OP_LT = 3'd6, OP_RSV = 3'd7;
  localparam logic [127:0] ONES64 = 128'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op_drv = 3'd0;
  logic [127:0] a_drv = '0;
  logic [127:0] b_drv = '0;
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  v2f_limb_alu_if #(.WIDTH(64))  if_u64 ();
  v2f_limb_alu_if #(.WIDTH(64))  if_s64 ();
  v2f_limb_alu_if #(.WIDTH(40))  if_u40 ();
  v2f_limb_alu_if #(.WIDTH(128)) if_u128 ();

  assign if_u64.in_valid  = in_valid;
  assign if_u64.out_ready = out_ready;
  assign if_u64.op        = op_drv;
  assign if_u64.a         = a_drv[63:0];
  assign if_u64.b         = b_drv[63:0];
  assign if_s64.in_valid  = in_valid;
  assign if_s64.out_ready = out_ready;
  assign if_s64.op        = op_drv;
  assign if_s64.a         = a_drv[63:0];
  assign if_s64.b         = b_drv[63:0];
  assign if_u40.in_valid  = in_valid;
  assign if_u40.out_ready = out_ready;
  assign if_u40.op        = op_drv;
  assign if_u40.a         = a_drv[39:0];
  assign if_u40.b         = b_drv[39:0];
  assign if_u128.in_valid  = in_valid;
  assign if_u128.out_ready = out_ready;
  assign if_u128.op        = op_drv;
  assign if_u128.a         = a_drv;
  assign if_u128.b         = b_drv;

  v2f_limb_alu #(.WIDTH(64), .LIMB_WIDTH(32), .A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_u64 (
    .clk_i(clk), .arst_i(arst), .bus_io(if_u64.slave));
  v2f_limb_alu #(.WIDTH(64), .LIMB_WIDTH(32), .A_SIGNED(1'b1), .B_SIGNED(1'b1)) u_s64 (
    .clk_i(clk), .arst_i(arst), .bus_io(if_s64.slave));
  v2f_limb_alu #(.WIDTH(40), .LIMB_WIDTH(32), .A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_u40 (
    .clk_i(clk), .arst_i(arst), .bus_io(if_u40.slave));
  v2f_limb_alu #(.WIDTH(128), .LIMB_WIDTH(32), .A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_u128 (
    .clk_i(clk), .arst_i(arst), .bus_io(if_u128.slave));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
    op_drv   = op;
    a_drv    = a;
    b_drv    = b;
    in_valid = 1'b1;
    cycles(1);
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
  endtask

  initial begin
    cycles(2);
    arst = 1'b0;
    cycles(1);
    chk("rst_in_ready", 128'(if_u64.in_ready), 128'd1);
    chk("rst_out_valid", 128'(if_u64.out_valid), 128'd0);
    chk("rst_y", 128'(if_u64.y), 128'd0);
    chk("rst_flag", 128'(if_u64.flag), 128'd0);
    chk("rst_in_ready128", 128'(if_u128.in_ready), 128'd1);

    // ADD carry at bit 63 / bit 39; latency 2 for 64-bit
    issue(OP_ADD, ONES64, 128'd1);
    cycles(1);
    chk("add_lat_t1", 128'(if_u64.out_valid), 128'd0);
    cycles(1);
    chk("add_lat_t2", 128'(if_u64.out_valid), 128'd1);
    chk("add64_y", 128'(if_u64.y), 128'd0);
    chk("add64_flag", 128'(if_u64.flag), 128'd1);
    chk("add40_y", 128'(if_u40.y), 128'd0);
    chk("add40_flag", 128'(if_u40.flag), 128'd1);
    cycles(2);
    chk("add128_y", if_u128.y, 128'h1_0000_0000_0000_0000);
    chk("add128_flag", 128'(if_u128.flag), 128'd0);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("bp_valid", 128'(if_u64.out_valid), 128'd1);
      chk("bp_y", 128'(if_u64.y), 128'd0);
      chk("bp_flag", 128'(if_u64.flag), 128'd1);
      chk("bp_in_ready", 128'(if_u64.in_ready), 128'd0);
    end
    retire();
    chk("retire_idle", 128'(if_u64.in_ready), 128'd1);

    issue(OP_SUB, 128'd0, 128'd1);
    cycles(4);
    chk("sub64_y", 128'(if_u64.y), ONES64);
    chk("sub64_flag", 128'(if_u64.flag), 128'd1);
    chk("sub40_y", 128'(if_u40.y), 128'hFF_FFFF_FFFF);
    chk("sub40_flag", 128'(if_u40.flag), 128'd1);
    chk("sub128_y", if_u128.y, {128{1'b1}});
    retire();

    issue(OP_SUB, 128'd5, 128'd3);
    cycles(4);
    chk("sub53_y", 128'(if_u64.y), 128'd2);
    chk("sub53_flag", 128'(if_u64.flag), 128'd0);
    chk("sub53_y128", if_u128.y, 128'd2);
    retire();

    issue(OP_LT, ONES64, 128'd1);
    cycles(4);
    chk("lt_s64_y", 128'(if_s64.y), 128'd1);
    chk("lt_s64_flag", 128'(if_s64.flag), 128'd1);
    chk("lt_u64_y", 128'(if_u64.y), 128'd0);
    chk("lt_u40_y", 128'(if_u40.y), 128'd0);
    retire();

    // Signed overflow case: min < max
    issue(OP_LT, 128'h8000_0000_0000_0000, 128'h7FFF_FFFF_FFFF_FFFF);
    cycles(4);
    chk("ltov_s64", 128'(if_s64.y), 128'd1);
    chk("ltov_u64", 128'(if_u64.y), 128'd0);
    chk("ltov_u40", 128'(if_u40.y), 128'd1);
    chk("ltov_u128", if_u128.y, 128'd0);
    retire();

    issue(OP_EQ, 128'h1234_5678_9ABC_DEF0, 128'h1234_5678_9ABC_DEF0);
    cycles(4);
    chk("eq_y", 128'(if_u64.y), 128'd1);
    chk("eq_flag", 128'(if_u64.flag), 128'd1);
    chk("eq_y128", if_u128.y, 128'd1);
    retire();

    // Differs only above bit 39
    issue(OP_EQ, 128'h1234_5678_9ABC_DEF0, 128'h1235_5678_9ABC_DEF0);
    cycles(4);
    chk("ne_y64", 128'(if_u64.y), 128'd0);
    chk("ne_flag64", 128'(if_u64.flag), 128'd0);
    chk("ne_y40", 128'(if_u40.y), 128'd1);
    retire();

    issue(OP_XOR, 128'hF0F0_F0F0_F0F0_F0F0, 128'hFF00_FF00_FF00_FF00);
    cycles(4);
    chk("xor_y", 128'(if_u64.y), 128'h0FF0_0FF0_0FF0_0FF0);
    chk("xor_flag", 128'(if_u64.flag), 128'd0);
    retire();

    issue(OP_RSV, ONES64, ONES64);
    cycles(1);
    chk("rsv_lat", 128'(if_u64.out_valid), 128'd0);
    cycles(1);
    chk("rsv_valid", 128'(if_u64.out_valid), 128'd1);
    chk("rsv_y", 128'(if_u64.y), 128'd0);
    chk("rsv_flag", 128'(if_u64.flag), 128'd0);
    cycles(2);
    retire();

    // Retire and new request on the same edge
    issue(OP_ADD, 128'd5, 128'd3);
    cycles(4);
    chk("pre_b2b_y", 128'(if_u64.y), 128'd8);
    op_drv    = OP_SUB;
    a_drv     = 128'd5;
    b_drv     = 128'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("done_in_ready", 128'(if_u64.in_ready), 128'(`ifdef V2F_LIMB_ALU_B2B_EN 1 `else 0 `endif));
    cycles(1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef V2F_LIMB_ALU_B2B_EN
    chk("b2b_run", 128'(if_u64.in_ready), 128'd0);
    cycles(1);
    chk("b2b_t1", 128'(if_u64.out_valid), 128'd0);
    cycles(1);
    chk("b2b_t2", 128'(if_u64.out_valid), 128'd1);
    chk("b2b_y", 128'(if_u64.y), 128'd2);
    cycles(2);
    retire();
`else
    chk("nob2b_idle", 128'(if_u64.in_ready), 128'd1);
    chk("nob2b_valid", 128'(if_u64.out_valid), 128'd0);
    cycles(2);
    chk("nob2b_nostart", 128'(if_u64.out_valid), 128'd0);
`endif

    // Asynchronous abort in the middle of a 128-bit operation
    issue(OP_ADD, {128{1'b1}}, 128'd1);
    cycles(2);
    arst = 1'b1;
    #1;
    chk("abort_valid", 128'(if_u128.out_valid), 128'd0);
    chk("abort_y", if_u128.y, 128'd0);
    chk("abort_flag", 128'(if_u128.flag), 128'd0);
    chk("abort_ready", 128'(if_u128.in_ready), 128'd1);
    #1;
    arst = 1'b0;
    cycles(1);
    chk("abort_stay", 128'(if_u128.out_valid), 128'd0);
    issue(OP_ADD, 128'd1, 128'd1);
    cycles(3);
    chk("fresh_t3", 128'(if_u128.out_valid), 128'd0);
    cycles(1);
    chk("fresh_t4", 128'(if_u128.out_valid), 128'd1);
    chk("fresh_y", if_u128.y, 128'd2);
    chk("fresh_flag", 128'(if_u128.flag), 128'd0);
    retire();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
